// File: rtl/mem_responder.sv
// Memory-side responder for the core load/store port: one request in flight, fixed access
// latency, word-addressed 64-bit backing RAM with byte-lane stores and right-aligned loads.
module mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    input  logic [3:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 2) ? (LATENCY - 2) : 0);
    localparam bit SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [3:0]  size;
    } req_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    req_t            req_q;
    logic            rsp_valid_q;
    logic [63:0]     rdata_q;
    logic            err_q;

    logic [63:0]     mem_q [DEPTH];

    req_t            req_in;
    req_t            cur;
    logic [63:0]     idx_full;
    logic [AW-1:0]   idx;
    logic [63:0]     size_mask;
    logic            size_ok;
    logic            misalign;
    logic            out_of_range;
    logic [63:0]     word;
    logic [63:0]     rdata_d;
    logic            err_d;
    logic            enter_resp;
    logic            mem_we;

    assign req_in = '{
        write: req_write,
        addr:  req_addr,
        wdata: req_wdata,
        wmask: req_wmask,
        size:  req_size
    };

    // With single-cycle latency the request is evaluated on its accept edge, before it is latched.
    assign cur = (state_q == IDLE) ? req_in : req_q;

    assign idx_full     = (cur.addr - BASE_ADDR) >> 3;
    assign idx          = idx_full[AW-1:0];
    assign out_of_range = (cur.addr < BASE_ADDR) || (idx_full >= 64'(DEPTH));

    always_comb begin
        size_mask = '0;
        size_ok   = 1'b1;
        misalign  = 1'b0;
        case (cur.size)
            4'b1000: begin
                size_mask = '1;
                misalign  = |cur.addr[2:0];
            end
            4'b0100: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                misalign  = |cur.addr[1:0];
            end
            4'b0010: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                misalign  = cur.addr[0];
            end
            4'b0001: begin
                size_mask = 64'h0000_0000_0000_00FF;
            end
            default: begin
                size_ok = 1'b0;
            end
        endcase
    end

    assign err_d   = out_of_range || !size_ok || misalign;
    assign word    = mem_q[idx];
    assign rdata_d = (err_d || cur.write) ? '0
                   : ((word >> {cur.addr[2:0], 3'b000}) & size_mask);

    assign enter_resp = ((state_q == IDLE) && req_valid && SINGLE_CYCLE)
                     || ((state_q == BUSY) && (cnt_q == '0));
    assign mem_we     = reset && enter_resp && cur.write && !err_d;

    // NOTE: the RAM array is deliberately left out of reset so it maps onto a plain RAM and keeps its contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (cur.wmask[i]) begin
                    mem_q[idx][8*i +: 8] <= cur.wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= req_in;
                        if (SINGLE_CYCLE) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rdata_q     <= rdata_d;
                err_q       <= err_d;
            end
        end
    end

    assign req_ready = (state_q == IDLE) && reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
